// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams ORD+1 coefficient words into an FIR coefficient
// RAM, then holds the FIR sample input at zero long enough to flush its
// delay line before handing the raw sample stream back.
module fir_coef_loader #(
  parameter int ORD         = 10,
  parameter int DATA_W      = 24,
  parameter int COEF_ADDR_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   coef_valid_i,
  input  logic [DATA_W-1:0]      coef_data_i,
  output logic                   coef_ready_o,
  input  logic [DATA_W-1:0]      u_i,
  output logic [DATA_W-1:0]      u_out,
  output logic [COEF_ADDR_W-1:0] coef_addr_out,
  output logic [DATA_W-1:0]      coef_out,
  output logic                   we_out,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [COEF_ADDR_W-1:0] LAST = COEF_ADDR_W'(ORD);

  state_t                 state;
  logic [COEF_ADDR_W-1:0] idx;
  logic [COEF_ADDR_W-1:0] fcnt;

  // Handshake and status come straight from the state register.
  assign coef_ready_o = (state == LOAD);
  assign busy_o       = (state != IDLE);

  // Load sequencer, registered FIR write port and sample gating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      idx           <= '0;
      fcnt          <= '0;
      u_out         <= '0;
      coef_addr_out <= '0;
      coef_out      <= '0;
      we_out        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      we_out <= 1'b0;
      done_o <= 1'b0;
      u_out  <= (state == IDLE) ? u_i : '0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          if (coef_valid_i) begin
            we_out        <= 1'b1;
            coef_addr_out <= idx;
            coef_out      <= coef_data_i;
            if (idx == LAST) begin
              state <= FLUSH;
              fcnt  <= '0;
              idx   <= '0;
            end else begin
              idx <= idx + COEF_ADDR_W'(1);
            end
          end
        end
        FLUSH: begin
          if (fcnt == LAST) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end else begin
            fcnt <= fcnt + COEF_ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with default parameters (ORD=10).
module tb_fir_coef_loader;

  localparam int ORD = 10;
  localparam int DW  = 24;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          coef_valid_i = 1'b0;
  logic [DW-1:0] coef_data_i = '0;
  logic          coef_ready_o;
  logic [DW-1:0] u_i = '0;
  logic [DW-1:0] u_out;
  logic [AW-1:0] coef_addr_out;
  logic [DW-1:0] coef_out;
  logic          we_out;
  logic          busy_o;
  logic          done_o;

  int vec = 0;
  int bad = 0;
  int cyc = 0;

  fir_coef_loader #(.ORD(ORD), .DATA_W(DW), .COEF_ADDR_W(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .coef_valid_i (coef_valid_i),
    .coef_data_i  (coef_data_i),
    .coef_ready_o (coef_ready_o),
    .u_i          (u_i),
    .u_out        (u_out),
    .coef_addr_out(coef_addr_out),
    .coef_out     (coef_out),
    .we_out       (we_out),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One load starting with start_i in relative cycle 0. Word k transfers in
  // cycle k+1, plus gap_len stall cycles for words after word 4.
  task automatic run_load(input int gap_len, input bit extra, input bit pulses, input int base);
    int last_c;
    int k;
    int ek;
    int tk;
    int last_we;
    last_c  = 25 + gap_len;
    last_we = ORD + 1 + gap_len + 1;
    for (int c = 0; c <= last_c; c++) begin
      k  = -1;
      ek = -1;
      for (int kk = 0; kk <= ORD; kk++) begin
        tk = kk + 1 + ((kk > 4) ? gap_len : 0);
        if (tk == c)     k  = kk;
        if (tk + 1 == c) ek = kk;
      end
      start_i      = (c == 0) || (pulses && (c == 5 || c == 15));
      coef_valid_i = (k >= 0) || (c == 0) || (extra && c > 11 + gap_len);
      coef_data_i  = DW'((k >= 0) ? base + k : base + 85);
      u_i          = DW'(32'h1000 + c);

      check("we", 32'(we_out), 32'(ek >= 0));
      if (ek >= 0) begin
        check("addr", 32'(coef_addr_out), 32'(ek));
        check("coef", 32'(coef_out), 32'(base + ek));
      end else if (c > last_we) begin
        check("addr_hold", 32'(coef_addr_out), 32'(ORD));
        check("coef_hold", 32'(coef_out), 32'(base + ORD));
      end
      check("busy", 32'(busy_o), 32'(c >= 1 && c <= 22 + gap_len));
      check("ready", 32'(coef_ready_o), 32'(c >= 1 && c <= 11 + gap_len));
      check("done", 32'(done_o), 32'(c == 23 + gap_len));
      if (c >= 1)
        check("u_out", 32'(u_out),
              (c >= 2 && c <= 23 + gap_len) ? 32'd0 : 32'h1000 + 32'(c - 1));
      tick();
    end
    start_i      = 1'b0;
    coef_valid_i = 1'b0;
  endtask

  initial begin
    // Reset, then idle pass-through.
    rst_i = 1'b1;
    u_i   = DW'(3);
    tick();
    check("rst_u", 32'(u_out), 0);
    check("rst_addr", 32'(coef_addr_out), 0);
    check("rst_coef", 32'(coef_out), 0);
    check("rst_we", 32'(we_out), 0);
    check("rst_ready", 32'(coef_ready_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    rst_i = 1'b0;
    u_i   = DW'(5);
    tick();
    check("idle_u5", 32'(u_out), 5);
    check("idle_we", 32'(we_out), 0);
    u_i = DW'(7);
    tick();
    check("idle_u7", 32'(u_out), 7);
    check("idle_we2", 32'(we_out), 0);

    // Full load with extra words and stray start pulses.
    run_load(0, 1'b1, 1'b1, 100);
    tick();
    // Stalled load: 3 idle cycles after word 4.
    run_load(3, 1'b0, 1'b0, 200);
    tick();

    // Reset after 6 words.
    for (int c = 0; c <= 7; c++) begin
      start_i      = (c == 0);
      coef_valid_i = (c >= 1 && c <= 6);
      coef_data_i  = DW'(500 + c - 1);
      rst_i        = (c == 7);
      check("ml_we", 32'(we_out), 32'(c >= 2 && c <= 7));
      if (c >= 2) check("ml_addr", 32'(coef_addr_out), 32'(c - 2));
      tick();
    end
    rst_i        = 1'b0;
    coef_valid_i = 1'b1;
    check("ab_u", 32'(u_out), 0);
    check("ab_addr", 32'(coef_addr_out), 0);
    check("ab_coef", 32'(coef_out), 0);
    check("ab_we", 32'(we_out), 0);
    check("ab_ready", 32'(coef_ready_o), 0);
    check("ab_busy", 32'(busy_o), 0);
    check("ab_done", 32'(done_o), 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("ab_we_idle", 32'(we_out), 0);
      check("ab_done_idle", 32'(done_o), 0);
      check("ab_busy_idle", 32'(busy_o), 0);
    end
    coef_valid_i = 1'b0;
    tick();
    run_load(0, 1'b0, 1'b0, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
